// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: walks weight/input addresses and MAC strobes for every neuron of a layer.
// Optional SEQ_CMD_ERR_EN adds a sticky cmd_err flag for command collisions.
module nn_layer_sequencer #(
   parameter int IN_SIZE  = 4,
   parameter int H1_SIZE  = 3,
   parameter int H2_SIZE  = 2,
   parameter int OUT_SIZE = 2,
   parameter int IDX_W    = 8,
   parameter int WADDR_W  = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld1,
   input  logic               ld2,
   input  logic               calc,
   output logic               busy,
   output logic [WADDR_W-1:0] weight_addr,
   output logic [IDX_W-1:0]   in_addr,
   output logic [1:0]         layer_sel,
   output logic               mac_clr,
   output logic               mac_en,
   output logic               neuron_wr,
   output logic [IDX_W-1:0]   neuron_idx,
   output logic               hidden_layer_1_done,
   output logic               hidden_layer_2_done,
   output logic               calculation_done,
   output logic [2:0]         fsm_state
`ifdef SEQ_CMD_ERR_EN
   ,
   output logic               cmd_err
`endif
);

   localparam int TOTAL_W = IN_SIZE*H1_SIZE + H1_SIZE*H2_SIZE + H2_SIZE*OUT_SIZE;

   generate
      if (IN_SIZE < 1 || H1_SIZE < 1 || H2_SIZE < 1 || OUT_SIZE < 1 ||
          IN_SIZE >= (1 << IDX_W) || H1_SIZE >= (1 << IDX_W) ||
          H2_SIZE >= (1 << IDX_W) || OUT_SIZE >= (1 << IDX_W) ||
          TOTAL_W > (1 << WADDR_W)) begin : g_size_check
         $error("nn_layer_sequencer: layer sizes do not fit IDX_W/WADDR_W");
      end
   endgenerate

   localparam logic [IDX_W-1:0]   L1_KM   = IDX_W'(IN_SIZE - 1);
   localparam logic [IDX_W-1:0]   L1_NM   = IDX_W'(H1_SIZE - 1);
   localparam logic [WADDR_W-1:0] L1_BASE = '0;
   localparam logic [IDX_W-1:0]   L2_KM   = IDX_W'(H1_SIZE - 1);
   localparam logic [IDX_W-1:0]   L2_NM   = IDX_W'(H2_SIZE - 1);
   localparam logic [WADDR_W-1:0] L2_BASE = WADDR_W'(IN_SIZE*H1_SIZE);
   localparam logic [IDX_W-1:0]   LO_KM   = IDX_W'(H2_SIZE - 1);
   localparam logic [IDX_W-1:0]   LO_NM   = IDX_W'(OUT_SIZE - 1);
   localparam logic [WADDR_W-1:0] LO_BASE = WADDR_W'(IN_SIZE*H1_SIZE + H1_SIZE*H2_SIZE);

   // fsm_state mirrors this encoding for observation.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAC   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [1:0]         sel_r;
   logic [IDX_W-1:0]   k, n, k_max, n_max;
   logic [WADDR_W-1:0] waddr_r;
   logic               mac_en_r;

   logic               cmd_go;
   logic [1:0]         sel_nxt;
   logic [IDX_W-1:0]   kmax_nxt, nmax_nxt;
   logic [WADDR_W-1:0] base_nxt;

   // Commands are single-cycle strobes with no ready/ack: they are taken only in IDLE,
   // highest priority ld1 > ld2 > calc, and any strobe seen in another state is dropped.
   always_comb begin
      cmd_go   = ld1 | ld2 | calc;
      sel_nxt  = 2'd0;
      kmax_nxt = L1_KM;
      nmax_nxt = L1_NM;
      base_nxt = L1_BASE;
      if (ld1) begin
         sel_nxt  = 2'd0;
         kmax_nxt = L1_KM;
         nmax_nxt = L1_NM;
         base_nxt = L1_BASE;
      end else if (ld2) begin
         sel_nxt  = 2'd1;
         kmax_nxt = L2_KM;
         nmax_nxt = L2_NM;
         base_nxt = L2_BASE;
      end else if (calc) begin
         sel_nxt  = 2'd2;
         kmax_nxt = LO_KM;
         nmax_nxt = LO_NM;
         base_nxt = LO_BASE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_go) state_nxt = MAC;
         MAC:     if (k == k_max) state_nxt = DRAIN;
         DRAIN:   state_nxt = WRITE;
         WRITE:   state_nxt = (n == n_max) ? DONE : MAC;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The weight address is a running counter, so it steps straight across neuron boundaries.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sel_r    <= '0;
         k        <= '0;
         n        <= '0;
         k_max    <= '0;
         n_max    <= '0;
         waddr_r  <= '0;
         mac_en_r <= 1'b0;
      end else begin
         mac_en_r <= (state == MAC);
         case (state)
            IDLE: begin
               if (cmd_go) begin
                  sel_r   <= sel_nxt;
                  k_max   <= kmax_nxt;
                  n_max   <= nmax_nxt;
                  waddr_r <= base_nxt;
                  k       <= '0;
                  n       <= '0;
               end
            end
            MAC: begin
               waddr_r <= waddr_r + WADDR_W'(1);
               if (k != k_max) k <= k + IDX_W'(1);
            end
            WRITE: begin
               if (n != n_max) begin
                  n <= n + IDX_W'(1);
                  k <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy                = (state == MAC) || (state == DRAIN) || (state == WRITE);
   assign weight_addr         = waddr_r;
   assign in_addr             = k;
   assign layer_sel           = sel_r;
   assign mac_clr             = (state == MAC) && (k == '0);
   assign mac_en              = mac_en_r;
   assign neuron_wr           = (state == WRITE);
   assign neuron_idx          = n;
   assign hidden_layer_1_done = (state == DONE) && (sel_r == 2'd0);
   assign hidden_layer_2_done = (state == DONE) && (sel_r == 2'd1);
   assign calculation_done    = (state == DONE) && (sel_r == 2'd2);
   assign fsm_state           = state;

`ifdef SEQ_CMD_ERR_EN
   logic cmd_multi;
   assign cmd_multi = (ld1 & ld2) | (ld1 & calc) | (ld2 & calc);

   always_ff @(posedge clk) begin
      if (!rst) cmd_err <= 1'b0;
      else if ((busy && cmd_go) || (state == IDLE && cmd_multi)) cmd_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer (default sizes 4/3/2/2); checks cmd_err when
// SEQ_CMD_ERR_EN is defined.
module tb_nn_layer_sequencer;

   localparam int IDX_W   = 8;
   localparam int WADDR_W = 12;

   logic               clk;
   logic               rst;
   logic               ld1, ld2, calc;
   logic               busy;
   logic [WADDR_W-1:0] weight_addr;
   logic [IDX_W-1:0]   in_addr;
   logic [1:0]         layer_sel;
   logic               mac_clr, mac_en, neuron_wr;
   logic [IDX_W-1:0]   neuron_idx;
   logic               hidden_layer_1_done, hidden_layer_2_done, calculation_done;
   logic [2:0]         fsm_state;
`ifdef SEQ_CMD_ERR_EN
   logic               cmd_err;
`endif

   int total = 0;
   int bad   = 0;

   nn_layer_sequencer dut (
      .clk                 (clk),
      .rst                 (rst),
      .ld1                 (ld1),
      .ld2                 (ld2),
      .calc                (calc),
      .busy                (busy),
      .weight_addr         (weight_addr),
      .in_addr             (in_addr),
      .layer_sel           (layer_sel),
      .mac_clr             (mac_clr),
      .mac_en              (mac_en),
      .neuron_wr           (neuron_wr),
      .neuron_idx          (neuron_idx),
      .hidden_layer_1_done (hidden_layer_1_done),
      .hidden_layer_2_done (hidden_layer_2_done),
      .calculation_done    (calculation_done),
      .fsm_state           (fsm_state)
`ifdef SEQ_CMD_ERR_EN
      ,
      .cmd_err             (cmd_err)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; ld1 = 1'b0; ld2 = 1'b0; calc = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   function automatic logic [36:0] all_outs();
      return {busy, weight_addr, in_addr, layer_sel, mac_clr, mac_en, neuron_wr,
              neuron_idx, hidden_layer_1_done, hidden_layer_2_done, calculation_done};
   endfunction

   task automatic test_reset();
      rst = 1'b0; ld1 = 1'b1; ld2 = 1'b0; calc = 1'b0;
      tick();
      tick();
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", all_outs());
      end
      total++;
      if (fsm_state !== 3'd0) begin
         bad++;
         $display("FAIL reset_state got=%0d exp=0", fsm_state);
      end
`ifdef SEQ_CMD_ERR_EN
      total++;
      if (cmd_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_cmd_err got=%b exp=0", cmd_err);
      end
`endif
      ld1 = 1'b0;
      rst = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || fsm_state !== 3'd0) begin
         bad++;
         $display("FAIL idle_after_reset busy=%b state=%0d exp busy=0 state=0", busy, fsm_state);
      end
   endtask

   // Layer 1, then layer 2, then output layer, every cycle checked against the schedule.
   task automatic test_full_network();
      int kk, nn, base, n, p;
      logic [2:0] exp_done;
      logic [2:0] dn;
      for (int l = 0; l < 3; l++) begin
         kk = 4; nn = 3; base = 0; exp_done = 3'b100;
         case (l)
            0: begin kk = 4; nn = 3; base = 0;  exp_done = 3'b100; ld1  = 1'b1; end
            1: begin kk = 3; nn = 2; base = 12; exp_done = 3'b010; ld2  = 1'b1; end
            default: begin kk = 2; nn = 2; base = 18; exp_done = 3'b001; calc = 1'b1; end
         endcase
         tick();
         ld1 = 1'b0; ld2 = 1'b0; calc = 1'b0;
         for (int c = 1; c <= nn*(kk+2); c++) begin
            n = (c-1) / (kk+2);
            p = (c-1) % (kk+2);
            dn = {hidden_layer_1_done, hidden_layer_2_done, calculation_done};
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL busy l=%0d c=%0d got=%b exp=1", l, c, busy);
            end
            total++;
            if (layer_sel !== 2'(l)) begin
               bad++;
               $display("FAIL layer_sel l=%0d c=%0d got=%0d exp=%0d", l, c, layer_sel, l);
            end
            if (p < kk) begin
               total++;
               if (weight_addr !== WADDR_W'(base + n*kk + p)) begin
                  bad++;
                  $display("FAIL weight_addr l=%0d c=%0d got=%0d exp=%0d", l, c, weight_addr, base + n*kk + p);
               end
               total++;
               if (in_addr !== IDX_W'(p)) begin
                  bad++;
                  $display("FAIL in_addr l=%0d c=%0d got=%0d exp=%0d", l, c, in_addr, p);
               end
            end
            total++;
            if (mac_clr !== (p == 0)) begin
               bad++;
               $display("FAIL mac_clr l=%0d c=%0d got=%b exp=%b", l, c, mac_clr, (p == 0));
            end
            total++;
            if (mac_en !== (p >= 1 && p <= kk)) begin
               bad++;
               $display("FAIL mac_en l=%0d c=%0d got=%b exp=%b", l, c, mac_en, (p >= 1 && p <= kk));
            end
            total++;
            if (neuron_wr !== (p == kk+1)) begin
               bad++;
               $display("FAIL neuron_wr l=%0d c=%0d got=%b exp=%b", l, c, neuron_wr, (p == kk+1));
            end
            if (p == kk+1) begin
               total++;
               if (neuron_idx !== IDX_W'(n)) begin
                  bad++;
                  $display("FAIL neuron_idx l=%0d c=%0d got=%0d exp=%0d", l, c, neuron_idx, n);
               end
            end
            total++;
            if (dn !== 3'b000) begin
               bad++;
               $display("FAIL early_done l=%0d c=%0d got=%b exp=000", l, c, dn);
            end
            tick();
         end
         dn = {hidden_layer_1_done, hidden_layer_2_done, calculation_done};
         total++;
         if (dn !== exp_done || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse l=%0d got=%b busy=%b exp=%b busy=0", l, dn, busy, exp_done);
         end
         tick();
         dn = {hidden_layer_1_done, hidden_layer_2_done, calculation_done};
         total++;
         if (dn !== 3'b000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL after_done l=%0d got=%b busy=%b exp=000 busy=0", l, dn, busy);
         end
      end
`ifdef SEQ_CMD_ERR_EN
      total++;
      if (cmd_err !== 1'b0) begin
         bad++;
         $display("FAIL clean_cmd_err got=%b exp=0", cmd_err);
      end
`endif
   endtask

   task automatic test_priority();
      int h1, h2, cd, bcyc, wmax;
      h1 = 0; h2 = 0; cd = 0; bcyc = 0; wmax = 0;
      ld1 = 1'b1; ld2 = 1'b1; calc = 1'b1;
      tick();
      ld1 = 1'b0; ld2 = 1'b0; calc = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         if (hidden_layer_1_done) h1++;
         if (hidden_layer_2_done) h2++;
         if (calculation_done)    cd++;
         if (busy) begin
            bcyc++;
            if (int'(weight_addr) > wmax) wmax = int'(weight_addr);
         end
         tick();
      end
      total++;
      if (h1 != 1 || h2 != 0 || cd != 0) begin
         bad++;
         $display("FAIL priority_dones got h1=%0d h2=%0d cd=%0d exp 1/0/0", h1, h2, cd);
      end
      total++;
      if (bcyc != 18) begin
         bad++;
         $display("FAIL priority_busy got=%0d exp=18", bcyc);
      end
      total++;
      if (wmax != 12) begin
         bad++;
         $display("FAIL priority_waddr_max got=%0d exp=12", wmax);
      end
`ifdef SEQ_CMD_ERR_EN
      total++;
      if (cmd_err !== 1'b1) begin
         bad++;
         $display("FAIL priority_cmd_err got=%b exp=1", cmd_err);
      end
`endif
   endtask

   task automatic test_busy_ignore();
      int h1, h2, bcyc;
      h1 = 0; h2 = 0; bcyc = 0;
      do_reset();
      ld1 = 1'b1;
      tick();
      ld1 = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (hidden_layer_1_done) h1++;
         if (hidden_layer_2_done) h2++;
         if (busy) bcyc++;
         ld2 = (c == 5);
         tick();
      end
      ld2 = 1'b0;
      total++;
      if (h1 != 1 || h2 != 0) begin
         bad++;
         $display("FAIL busy_ignore_dones got h1=%0d h2=%0d exp 1/0", h1, h2);
      end
      total++;
      if (bcyc != 18) begin
         bad++;
         $display("FAIL busy_ignore_busy got=%0d exp=18", bcyc);
      end
`ifdef SEQ_CMD_ERR_EN
      total++;
      if (cmd_err !== 1'b1) begin
         bad++;
         $display("FAIL busy_cmd_err got=%b exp=1", cmd_err);
      end
      for (int c = 0; c < 5; c++) tick();
      total++;
      if (cmd_err !== 1'b1) begin
         bad++;
         $display("FAIL sticky_cmd_err got=%b exp=1", cmd_err);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int h1;
      h1 = 0;
      do_reset();
      ld1 = 1'b1;
      tick();
      ld1 = 1'b0;
      for (int c = 1; c < 12; c++) tick();
      total++;
      if (neuron_wr !== 1'b1 || neuron_idx !== IDX_W'(1)) begin
         bad++;
         $display("FAIL mid_position wr=%b idx=%0d exp wr=1 idx=1", neuron_wr, neuron_idx);
      end
      rst = 1'b0;
      tick();
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs got=%h exp=0", all_outs());
      end
      total++;
      if (fsm_state !== 3'd0) begin
         bad++;
         $display("FAIL mid_reset_state got=%0d exp=0", fsm_state);
      end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if ({hidden_layer_1_done, hidden_layer_2_done, calculation_done, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_quiet c=%0d got=%b exp=0000", c,
                     {hidden_layer_1_done, hidden_layer_2_done, calculation_done, busy});
         end
      end
      ld1 = 1'b1;
      tick();
      ld1 = 1'b0;
      total++;
      if (busy !== 1'b1 || weight_addr !== '0 || in_addr !== '0 || mac_clr !== 1'b1) begin
         bad++;
         $display("FAIL restart got busy=%b waddr=%0d in=%0d clr=%b exp 1/0/0/1",
                  busy, weight_addr, in_addr, mac_clr);
      end
      for (int c = 1; c <= 19; c++) begin
         if (hidden_layer_1_done) h1++;
         tick();
      end
      total++;
      if (h1 != 1) begin
         bad++;
         $display("FAIL restart_done got=%0d exp=1", h1);
      end
   endtask

   initial begin
      rst = 1'b0; ld1 = 1'b0; ld2 = 1'b0; calc = 1'b0;
      test_reset();
      test_full_network();
      test_priority();
      test_busy_ignore();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Datapath-side responder to the network controller FSM.
- Accepts one-cycle layer commands (layer 1, layer 2, output calculation) and sequences the weight/input memory addresses and MAC enables for every neuron of that layer.
- Writes each neuron result back, then returns a one-cycle done pulse per layer: hidden_layer_1_done, hidden_layer_2_done or calculation_done.

Parameters:
- IN_SIZE, 4, inputs per sample (layer-1 fan-in)
- H1_SIZE, 3, neurons in hidden layer 1
- H2_SIZE, 2, neurons in hidden layer 2
- OUT_SIZE, 2, output neurons
- IDX_W, 8, width of input/neuron index counters
- WADDR_W, 12, weight memory address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- ld1  in  1  command: run hidden layer 1
- ld2  in  1  command: run hidden layer 2
- calc  in  1  command: run output layer
- busy  out  1  high while a layer is in progress
- weight_addr  out  WADDR_W  weight memory read address
- in_addr  out  IDX_W  source-vector read index (input or previous layer)
- layer_sel  out  2  0 = layer1, 1 = layer2, 2 = output (valid while busy)
- mac_clr  out  1  clear accumulator
- mac_en  out  1  accumulate data returned from memory this cycle
- neuron_wr  out  1  write accumulator (post-activation) to result slot
- neuron_idx  out  IDX_W  result slot index for neuron_wr
- hidden_layer_1_done  out  1  one-cycle pulse, layer 1 complete
- hidden_layer_2_done  out  1  one-cycle pulse, layer 2 complete
- calculation_done  out  1  one-cycle pulse, output layer complete

Behaviour:
- Reset (rst==0 at a clk edge):
  - All outputs 0, FSM to IDLE, all counters 0.
  - Reset mid-layer aborts the layer with no done pulse.
- Per-layer geometry, K = fan-in, N = neurons:
  - layer 1: K = IN_SIZE, N = H1_SIZE, weight base 0.
  - layer 2: K = H1_SIZE, N = H2_SIZE, weight base IN_SIZE*H1_SIZE.
  - output: K = H2_SIZE, N = OUT_SIZE, weight base IN_SIZE*H1_SIZE + H1_SIZE*H2_SIZE.
- FSM states: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - Commands are sampled here only. Priority: ld1 > ld2 > calc; lower-priority commands in the same cycle are dropped.
  - On accept: latch layer_sel and K/N/base, clear k and n, weight_addr = base, go to MAC.
- MAC (one cycle per k, k = 0..K-1):
  - in_addr = k; weight_addr = base + n*K + k, implemented as a running counter that increments every MAC cycle.
  - mac_clr = 1 only when k == 0.
  - When k == K-1, go to DRAIN.
- mac_en is a 1-cycle-delayed copy of "state == MAC", matching synchronous memory read latency 1. It is therefore high in the cycles after MAC cycles 0..K-1, the last of these being the DRAIN cycle.
- DRAIN: one cycle, no address issued; last mac_en occurs here.
- WRITE: one cycle.
  - neuron_wr = 1, neuron_idx = n.
  - If n == N-1, go to DONE; otherwise n++, k = 0, go to MAC.
- DONE: one cycle.
  - Pulse the done output matching layer_sel; busy = 0 in this cycle; return to IDLE.
  - A command is not accepted in DONE; the earliest new accept is the following IDLE cycle.
- busy is 1 in MAC/DRAIN/WRITE.
- Latency: command accept edge to done pulse = N*(K+2) busy cycles, then the DONE cycle.
- Commands arriving while busy are ignored (controller holds ld/hidden until done).
- Counters never wrap: K and N are bounded by parameters; an elaboration check requires every size < 2**IDX_W and the total weight count ≤ 2**WADDR_W.

Optional Feature:
- Macro: SEQ_CMD_ERR_EN
- Defined:
  - Adds output port cmd_err (1 bit), reset 0.
  - cmd_err is sticky. It is set when any of ld1/ld2/calc is high while busy, or when more than one is high in the same IDLE cycle.
  - It is cleared only by reset. The ignore and priority behaviour above is unchanged.
- Undefined: no cmd_err port; collisions are silently ignored or prioritised as above.

Test Plan (default parameters):
- Reset, then ld1 pulse → busy = 1 for 18 cycles (3*(4+2)); weight_addr 0..11 issued in MAC cycles; neuron_wr at neuron_idx 0, 1, 2; hidden_layer_1_done pulses exactly once on cycle 19; busy = 0.
- ld2 after layer 1 → layer_sel = 1, first weight_addr = 12, last = 17; 2 neuron_wr; hidden_layer_2_done after 10 busy cycles. Then calc → weight_addr 18..21, calculation_done after 8 busy cycles.
- mac_clr/mac_en timing, layer 1 neuron 0:
  - mac_clr on the MAC cycle with in_addr = 0.
  - mac_en high on the 4 consecutive cycles starting one cycle after mac_clr.
  - neuron_wr on the cycle immediately after the last mac_en.
- ld1, ld2 and calc high together in IDLE → layer 1 runs; no layer-2 or output activity; with SEQ_CMD_ERR_EN, cmd_err = 1.
- ld2 pulsed mid-layer-1 → ignored; only hidden_layer_1_done is produced; with SEQ_CMD_ERR_EN, cmd_err latches 1 and stays 1 until reset.
- rst = 0 during layer-1 WRITE of neuron 1 → next cycle all outputs 0 and state IDLE; no done pulse; a subsequent ld1 restarts from weight_addr 0.
